// File: rtl/key_press_decoder_pkg.sv
// Shared types and default timing for the push-button gesture decoder.
// All timing values are in units of the 1 ms tick.
package key_pkg;

  // Width of every ms counter; must exceed the largest timing value below.
  localparam int unsigned CNT_W = 11;

  localparam int unsigned DEF_DEBOUNCE_MS = 20;
  localparam int unsigned DEF_LONG_MS     = 1000;
  localparam int unsigned DEF_GAP_MS      = 300;
  localparam int unsigned DEF_REPEAT_MS   = 200;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HOLD
  } keyState_t;

endpackage

// File: rtl/key_press_decoder_debounce.sv
// Two-flop synchronizer on the raw active-low pin followed by a tick-based
// stable counter producing the debounced, active-high key level.
module key_debounce #(
  parameter int unsigned DEBOUNCE_MS = key_pkg::DEF_DEBOUNCE_MS,
  parameter int unsigned CNT_W       = key_pkg::CNT_W
) (
  input  logic clk,
  input  logic rstN,
  input  logic iTick1ms,
  input  logic iKeyN,
  output logic oKeyLevel
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [1:0]       syncN;
  logic             syncPressed;
  logic [CNT_W-1:0] stableCnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncN <= '1;
    end else begin
      syncN <= {syncN[0], iKeyN};
    end
  end

  assign syncPressed = ~syncN[1];

  // Any clock where the synchronized pin agrees with the accepted level
  // restarts the count, so only uninterrupted runs of ticks qualify.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stableCnt <= '0;
      oKeyLevel <= 1'b0;
    end else if (syncPressed == oKeyLevel) begin
      stableCnt <= '0;
    end else if (iTick1ms) begin
      if (stableCnt == STABLE_LAST) begin
        oKeyLevel <= ~oKeyLevel;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_press_decoder.sv
// Push-button gesture decoder: short, long and double press events plus the
// debounced level. Optional auto-repeat while long-held: define KEY_REPEAT_EN.
module key_press_decoder #(
  parameter int unsigned DEBOUNCE_MS = key_pkg::DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = key_pkg::DEF_LONG_MS,
  parameter int unsigned GAP_MS      = key_pkg::DEF_GAP_MS,
  parameter int unsigned REPEAT_MS   = key_pkg::DEF_REPEAT_MS,
  parameter int unsigned CNT_W       = key_pkg::CNT_W
) (
  input  logic clk,
  input  logic rstN,
  input  logic iTick1ms,
  input  logic iKeyN,
  output logic oKeyLevel,
  output logic oShortPress,
  output logic oLongPress,
  output logic oDoublePress,
  output logic oRepeat
);

  import key_pkg::*;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MS - 1);

  keyState_t        state;
  logic [CNT_W-1:0] msCnt;
  logic             keyLevelD;
  logic             pressEdge;
  logic             releaseEdge;

  key_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .CNT_W       (CNT_W)
  ) uDebounce (
    .clk       (clk),
    .rstN      (rstN),
    .iTick1ms  (iTick1ms),
    .iKeyN     (iKeyN),
    .oKeyLevel (oKeyLevel)
  );

  assign pressEdge   =  oKeyLevel & ~keyLevelD;
  assign releaseEdge = ~oKeyLevel &  keyLevelD;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
  logic [CNT_W-1:0] repCnt;
`else
  logic unusedRepeatMs;
  assign unusedRepeatMs = ^CNT_W'(REPEAT_MS);
  assign oRepeat        = 1'b0;
`endif

  // Edges are tested before terminal counts in every state, so an edge that
  // coincides with the deciding tick suppresses the timeout event.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      msCnt        <= '0;
      keyLevelD    <= 1'b0;
      oShortPress  <= 1'b0;
      oLongPress   <= 1'b0;
      oDoublePress <= 1'b0;
`ifdef KEY_REPEAT_EN
      repCnt       <= '0;
      oRepeat      <= 1'b0;
`endif
    end else begin
      keyLevelD    <= oKeyLevel;
      oShortPress  <= 1'b0;
      oLongPress   <= 1'b0;
      oDoublePress <= 1'b0;
`ifdef KEY_REPEAT_EN
      oRepeat      <= 1'b0;
`endif
      if (iTick1ms && (msCnt != '1)) begin
        msCnt <= msCnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (pressEdge) begin
            state <= PRESS1;
            msCnt <= '0;
          end
        end

        PRESS1: begin
          if (releaseEdge) begin
            state <= WAIT_GAP;
            msCnt <= '0;
          end else if (iTick1ms && (msCnt == LONG_LAST)) begin
            oLongPress <= 1'b1;
            state      <= LONG_HOLD;
            msCnt      <= '0;
`ifdef KEY_REPEAT_EN
            repCnt     <= '0;
`endif
          end
        end

        WAIT_GAP: begin
          if (pressEdge) begin
            state <= PRESS2;
            msCnt <= '0;
          end else if (iTick1ms && (msCnt == GAP_LAST)) begin
            oShortPress <= 1'b1;
            state       <= IDLE;
            msCnt       <= '0;
          end
        end

        PRESS2: begin
          if (releaseEdge) begin
            oDoublePress <= 1'b1;
            state        <= IDLE;
            msCnt        <= '0;
          end
        end

        LONG_HOLD: begin
          if (releaseEdge) begin
            state <= IDLE;
            msCnt <= '0;
          end
`ifdef KEY_REPEAT_EN
          else if (iTick1ms) begin
            if (repCnt == REP_LAST) begin
              oRepeat <= 1'b1;
              repCnt  <= '0;
            end else begin
              repCnt  <= repCnt + 1'b1;
            end
          end
`endif
        end

        default: begin
          state <= IDLE;
          msCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder; event times are measured in 1 ms
// ticks relative to pin changes and debounced edges.
`timescale 1ns/1ps
module tb_key_press_decoder;

  localparam int TICK_DIV = 6;

  logic clk = 1'b0;
  logic rstN;
  logic iTick1ms;
  logic iKeyN;
  logic oKeyLevel, oShortPress, oLongPress, oDoublePress, oRepeat;

  int numChecks = 0;
  int numErrors = 0;
  int tickCount = 0;
  int pinTick, rstTick;

  int riseCnt, fallCnt, riseTick, fallTick, firstFallTick;
  int shortCnt, longCnt, dblCnt, repPulses;
  int shortTick, firstShortTick, longTick, dblTick, firstRepTick, lastRepTick;
  int multiHot;
  logic lvlPrev = 1'b0;

  key_press_decoder uDut (
    .clk          (clk),
    .rstN         (rstN),
    .iTick1ms     (iTick1ms),
    .iKeyN        (iKeyN),
    .oKeyLevel    (oKeyLevel),
    .oShortPress  (oShortPress),
    .oLongPress   (oLongPress),
    .oDoublePress (oDoublePress),
    .oRepeat      (oRepeat)
  );

  always #5 clk = ~clk;

  initial begin
    int div;
    div      = 0;
    iTick1ms = 1'b0;
    forever begin
      @(negedge clk);
      if (div == TICK_DIV - 1) begin
        div      = 0;
        iTick1ms = 1'b1;
        tickCount++;
      end else begin
        div++;
        iTick1ms = 1'b0;
      end
    end
  end

  // Event monitor, sampled 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (oKeyLevel && !lvlPrev) begin riseCnt++; riseTick = tickCount; end
    if (!oKeyLevel && lvlPrev) begin
      if (fallCnt == 0) firstFallTick = tickCount;
      fallCnt++; fallTick = tickCount;
    end
    lvlPrev = oKeyLevel;
    if (oShortPress) begin
      if (shortCnt == 0) firstShortTick = tickCount;
      shortCnt++; shortTick = tickCount;
    end
    if (oLongPress)   begin longCnt++; longTick = tickCount; end
    if (oDoublePress) begin dblCnt++;  dblTick  = tickCount; end
    if (oRepeat) begin
      if (repPulses == 0) firstRepTick = tickCount;
      repPulses++; lastRepTick = tickCount;
    end
    if (int'(oShortPress) + int'(oLongPress) + int'(oDoublePress) + int'(oRepeat) > 1)
      multiHot++;
  end

  task automatic checkEq(input string tag, input int obs, input int exp);
    numChecks++;
    if (obs != exp) begin
      numErrors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearStats();
    riseCnt = 0; fallCnt = 0; shortCnt = 0; longCnt = 0; dblCnt = 0; repPulses = 0;
    riseTick = -1; fallTick = -1; firstFallTick = -1; shortTick = -1;
    firstShortTick = -1; longTick = -1; dblTick = -1;
    firstRepTick = -1; lastRepTick = -1;
  endtask

  // Returns two or three falling edges after the n-th tick is raised, well
  // clear of the next tick so pin changes land at a fixed tick phase.
  task automatic waitTicks(input int n);
    int target;
    target = tickCount + n;
    while (tickCount < target) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic setPin(input bit pressed);
    pinTick = tickCount;
    iKeyN   = ~pressed;
  endtask

  function automatic int outVec();
    return int'({oKeyLevel, oShortPress, oLongPress, oDoublePress, oRepeat});
  endfunction

  initial begin
    int p0, p1;
    multiHot = 0;
    clearStats();
    rstN  = 1'b0;
    iKeyN = 1'b1;
    repeat (4) @(negedge clk);
    checkEq("reset_outputs", outVec(), 0);
    rstN = 1'b1;
    waitTicks(2);
    checkEq("idle_level", int'(oKeyLevel), 0);

    // Glitch rejection: 5 ms low pulses every 30 ms
    clearStats();
    for (int i = 0; i < 10; i++) begin
      setPin(1'b1); waitTicks(5);
      setPin(1'b0); waitTicks(25);
    end
    checkEq("glitch_rises", riseCnt, 0);
    checkEq("glitch_events", shortCnt + longCnt + dblCnt + repPulses, 0);

    // Short press: 200 ms hold
    clearStats();
    setPin(1'b1); p0 = pinTick;
    waitTicks(19);
    checkEq("short_level_at_19", int'(oKeyLevel), 0);
    waitTicks(1);
    checkEq("short_level_at_20", int'(oKeyLevel), 1);
    checkEq("short_rise_latency", riseTick - p0, 20);
    waitTicks(180);
    setPin(1'b0); p1 = pinTick;
    waitTicks(350);
    checkEq("short_fall_latency", fallTick - p1, 20);
    checkEq("short_count", shortCnt, 1);
    checkEq("short_after_release", shortTick - fallTick, 300);
    checkEq("short_no_long_dbl", longCnt + dblCnt + repPulses, 0);

    // Long press: 1500 ms hold
    clearStats();
    setPin(1'b1); p0 = pinTick;
    waitTicks(1500);
    setPin(1'b0);
    waitTicks(400);
    checkEq("long_count", longCnt, 1);
    checkEq("long_time", longTick - p0, 1020);
    checkEq("long_no_short_dbl", shortCnt + dblCnt, 0);
`ifdef KEY_REPEAT_EN
    checkEq("repeat_count", repPulses, 2);
    checkEq("repeat_first", firstRepTick - longTick, 200);
    checkEq("repeat_second", lastRepTick - longTick, 400);
`else
    checkEq("repeat_absent", repPulses, 0);
`endif

    // Double press: 100 / 150 / 100
    clearStats();
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(150);
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(400);
    checkEq("dbl_count", dblCnt, 1);
    checkEq("dbl_at_release", dblTick - fallTick, 0);
    checkEq("dbl_no_short", shortCnt + longCnt, 0);

    // Gap of exactly 300 ticks: timeout wins, two separate short presses
    clearStats();
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(300);
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(400);
    checkEq("gap300_shorts", shortCnt, 2);
    checkEq("gap300_first_short", firstShortTick - firstFallTick, 300);
    checkEq("gap300_no_dbl", dblCnt, 0);

    // Gap of 299 ticks: still a double press
    clearStats();
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(299);
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(400);
    checkEq("gap299_dbl", dblCnt, 1);
    checkEq("gap299_no_short", shortCnt, 0);

    // Reset during WAIT_GAP suppresses the pending short press
    setPin(1'b1); waitTicks(100);
    setPin(1'b0); waitTicks(100);
    @(negedge clk);
    #1 rstN = 1'b0;
    #1 checkEq("rst_gap_outputs", outVec(), 0);
    clearStats();
    waitTicks(2);
    rstN = 1'b1;
    waitTicks(400);
    checkEq("rst_gap_no_events", shortCnt + longCnt + dblCnt + repPulses, 0);

    // Key held through reset: level drops at once, fresh press after debounce
    setPin(1'b1); waitTicks(50);
    checkEq("held_level_before_rst", int'(oKeyLevel), 1);
    #1 rstN = 1'b0;
    #1 checkEq("held_level_in_rst", int'(oKeyLevel), 0);
    clearStats();
    waitTicks(2);
    rstN = 1'b1; rstTick = tickCount;
    waitTicks(100);
    setPin(1'b0); waitTicks(400);
    checkEq("held_rise_after_rst", riseTick - rstTick, 20);
    checkEq("held_short_after_rst", shortCnt, 1);
    checkEq("held_no_other", longCnt + dblCnt, 0);

    checkEq("one_hot_events", multiHot, 0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/key_press_decoder.md
Name: key_press_decoder

Overview:
- Input-side counterpart to the LED blink pattern generator: reads a raw push-button pin and decodes user gestures.
- Timebase is the shared 1 ms tick; no other timers.
- Emits single-cycle events: short press, long press, double press. Also emits a debounced key level.
- Sits between the board pin and control logic such as mode select.

Parameters:
- DEBOUNCE_MS, 20: consecutive ms ticks the input must hold a new level before the level is accepted.
- LONG_MS, 1000: hold time in ms at which a press is classified as long.
- GAP_MS, 300: maximum release gap in ms between two presses for them to count as a double press.
- REPEAT_MS, 200: auto-repeat period in ms (used only with the optional feature).
- CNT_W, 11: width of the ms counters. Must satisfy 2^CNT_W > max(LONG_MS, GAP_MS, REPEAT_MS, DEBOUNCE_MS).

Ports:
- clk  input  1  system clock
- rstN  input  1  asynchronous active-low reset
- iTick1ms  input  1  one-clk pulse every 1 ms
- iKeyN  input  1  raw, asynchronous button pin; 0 = pressed
- oKeyLevel  output  1  debounced level; 1 = pressed
- oShortPress  output  1  one-clk pulse on a short press
- oLongPress  output  1  one-clk pulse on a long press
- oDoublePress  output  1  one-clk pulse on a double press
- oRepeat  output  1  one-clk auto-repeat pulse (optional feature)

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous, active-low on rstN; all flops clear immediately while rstN = 0.
- Reset values:
  - Synchronizer flops = 1 (released).
  - oKeyLevel = 0, all event pulses = 0.
  - FSM = IDLE, all counters = 0.
- Synchronizer: 2-flop synchronizer on iKeyN, then inverted to give syncPressed.
- Debounce:
  - stableCnt clears on any clk where syncPressed == oKeyLevel.
  - On iTick1ms with a mismatch: if stableCnt == DEBOUNCE_MS-1, toggle oKeyLevel and clear stableCnt; otherwise increment stableCnt.
  - Latency from pin change to oKeyLevel = 2 clk + DEBOUNCE_MS ticks.
  - Glitches shorter than DEBOUNCE_MS ticks never change oKeyLevel.
- Edges: press/release edges are derived from registered oKeyLevel and are one clk wide.
- FSM (msCnt clears on every state transition; msCnt increments on iTick1ms and saturates at all-ones):
  - IDLE: press edge -> PRESS1.
  - PRESS1:
    - release edge -> WAIT_GAP.
    - iTick1ms with msCnt == LONG_MS-1 -> pulse oLongPress, go to LONG_HOLD.
  - WAIT_GAP:
    - press edge -> PRESS2.
    - iTick1ms with msCnt == GAP_MS-1 -> pulse oShortPress, go to IDLE.
  - PRESS2: release edge -> pulse oDoublePress, go to IDLE. Hold time is ignored; a second long hold still yields a double press.
  - LONG_HOLD: release edge -> IDLE. No short or double press is reported for this gesture.
- Priority: if an edge and the terminal-count tick occur in the same clk, the edge wins (no timeout pulse).
- Event pulses are registered: asserted exactly one clk after the deciding cycle, for one clk. At most one event pulse is high per clk.
- A short press is reported GAP_MS ticks after release, never at release.
- Reset mid-gesture: everything returns to IDLE and no pulse is emitted. A key held through reset deasserts oKeyLevel and re-enters via a fresh press edge after debounce.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- With the macro defined:
  - In LONG_HOLD, a separate repCnt counts ticks.
  - oRepeat pulses one clk every REPEAT_MS ticks while still held. The first repeat occurs REPEAT_MS ticks after the oLongPress pulse.
  - repCnt clears on entry to LONG_HOLD.
- Without the macro: oRepeat is tied to 0, and repCnt and its logic are absent.

Decomposition:
- Shared package key_pkg holds:
  - the state enum (IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HOLD);
  - default timing constants;
  - CNT_W.
- One sub-module, key_debounce: synchronizer plus stable counter. Ports: clk, rstN, iTick1ms, iKeyN, oKeyLevel.

Test Plan:
- Glitch rejection: 5 ms low pulses on iKeyN, repeated 10 times at a 30 ms period -> oKeyLevel stays 0, no events.
- Short press: hold 200 ms, then release -> oKeyLevel rises 20 ticks after the press. Exactly one oShortPress pulse arrives 300 ticks after the debounced release.
- Long press: hold 1500 ms -> oLongPress fires once at 1000 ticks after the debounced press. No further events after release. With KEY_REPEAT_EN, oRepeat fires at +200 and +400 ticks.
- Double press: 100 ms press, 150 ms gap, 100 ms press -> one oDoublePress on the second debounced release. No oShortPress.
- Gap boundary: release gap of exactly 300 debounced ticks -> oShortPress and IDLE are reached first; the second press starts a new gesture. A 299-tick gap -> double press.
- Reset mid-operation: assert rstN = 0 during WAIT_GAP -> all outputs 0 immediately, no oShortPress after release of reset.
